// File: rtl/multi_mode_fifo_if.sv
// Bus bundle for multi_mode_fifo: request/data inputs plus occupancy and status outputs.
// master = the side issuing w_en/r_en, slave = the FIFO itself.
interface multi_mode_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 8
);
    logic                  w_en;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] data_out;
    logic [PTR_WIDTH:0]    count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  half_full;
    logic                  half_empty;
    logic                  write_error;
    logic                  read_error;

    modport master (
        output w_en, r_en, data_in, err_clr,
        input  data_out, count, full, empty, almost_full, almost_empty,
        input  half_full, half_empty, write_error, read_error
    );

    modport slave (
        input  w_en, r_en, data_in, err_clr,
        output data_out, count, full, empty, almost_full, almost_empty,
        output half_full, half_empty, write_error, read_error
    );
endinterface

// File: rtl/multi_mode_fifo.sv
// Single-clock FIFO with registered-read or first-word-fall-through output,
// registered occupancy/threshold flags and sticky overflow/underflow errors.
module multi_mode_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int PTR_WIDTH  = 8,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = DEPTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input logic              clk,
    input logic              rst,
    multi_mode_fifo_if.slave bus
);
    localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] HALF_C  = (PTR_WIDTH + 1)'(DEPTH / 2);
    localparam logic [PTR_WIDTH:0] AF_C    = (PTR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [PTR_WIDTH:0] AE_C    = (PTR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wptr;
    logic [PTR_WIDTH-1:0]  rptr;
    logic [PTR_WIDTH:0]    count_q;
    logic [PTR_WIDTH:0]    count_next;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  full_q;
    logic                  empty_q;
    logic                  almost_full_q;
    logic                  almost_empty_q;
    logic                  half_full_q;
    logic                  half_empty_q;
    logic                  write_error_q;
    logic                  read_error_q;

    // Handshake: w_en/r_en are requests sampled on the rising edge. A write is
    // accepted only if full is low and a read only if empty is low, both judged
    // on the registered current state (so a full FIFO rejects a write even when
    // a read is accepted in the same cycle). Rejected requests change nothing
    // except raising the matching sticky error flag.
    assign wr_acc = bus.w_en && !full_q;
    assign rd_acc = bus.r_en && !empty_q;

    always_comb begin
        count_next = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
            count_q <= count_next;
        end
    end

    // Flags come from count_next so they change on the same edge as count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            half_full_q    <= 1'b0;
            half_empty_q   <= 1'b1;
        end else begin
            full_q         <= (count_next == DEPTH_C);
            empty_q        <= (count_next == '0);
            almost_full_q  <= (count_next >= AF_C);
            almost_empty_q <= (count_next <= AE_C);
            half_full_q    <= (count_next >= HALF_C);
            half_empty_q   <= (count_next < HALF_C);
        end
    end

    // A new rejection in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_error_q <= 1'b0;
            read_error_q  <= 1'b0;
        end else begin
            if (bus.w_en && full_q) write_error_q <= 1'b1;
            else if (bus.err_clr)   write_error_q <= 1'b0;
            if (bus.r_en && empty_q) read_error_q <= 1'b1;
            else if (bus.err_clr)    read_error_q <= 1'b0;
        end
    end

    // Storage is deliberately not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr] <= bus.data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out = mem[rptr];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] rd_data;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)         rd_data <= '0;
                else if (rd_acc) rd_data <= mem[rptr];
            end
            assign bus.data_out = rd_data;
        end
    endgenerate

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.half_full    = half_full_q;
    assign bus.half_empty   = half_empty_q;
    assign bus.write_error  = write_error_q;
    assign bus.read_error   = read_error_q;
endmodule

// File: tb/tb_multi_mode_fifo.sv
// Bench for multi_mode_fifo: a registered-read and a FWFT instance (DEPTH=16,
// AF=12, AE=4) driven with identical stimulus and checked against hand values.
module tb_multi_mode_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int PW    = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] popped;

    multi_mode_fifo_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus0 ();
    multi_mode_fifo_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus1 ();

    multi_mode_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW), .FWFT(0),
                      .AF_LEVEL(12), .AE_LEVEL(4))
        dut_reg (.clk(clk), .rst(rst), .bus(bus0));

    multi_mode_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW), .FWFT(1),
                      .AF_LEVEL(12), .AE_LEVEL(4))
        dut_fwft (.clk(clk), .rst(rst), .bus(bus1));

    assign bus1.w_en    = bus0.w_en;
    assign bus1.r_en    = bus0.r_en;
    assign bus1.data_in = bus0.data_in;
    assign bus1.err_clr = bus0.err_clr;

    // {full, empty, almost_full, almost_empty, half_full, half_empty, count}
    logic [10:0] st0;
    logic [10:0] st1;
    assign st0 = {bus0.full, bus0.empty, bus0.almost_full, bus0.almost_empty,
                  bus0.half_full, bus0.half_empty, bus0.count};
    assign st1 = {bus1.full, bus1.empty, bus1.almost_full, bus1.almost_empty,
                  bus1.half_full, bus1.half_empty, bus1.count};

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] exp_status(input int n);
        logic [4:0] c;
        c = 5'(n);
        return {n == 16, n == 0, n >= 12, n <= 4, n >= 8, n < 8, c};
    endfunction

    // ---------------- driver ----------------
    // One clock of stimulus; returns #1 after the edge with the scoreboard updated.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic clr);
        bit wr_ok;
        bit rd_ok;
        wr_ok = w && (exp_q.size() < DEPTH);
        rd_ok = r && (exp_q.size() > 0);
        bus0.w_en    = w;
        bus0.r_en    = r;
        bus0.data_in = d;
        bus0.err_clr = clr;
        @(posedge clk);
        #1;
        if (rd_ok) popped = exp_q.pop_front();
        if (wr_ok) exp_q.push_back(d);
        bus0.w_en    = 1'b0;
        bus0.r_en    = 1'b0;
        bus0.err_clr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus0.w_en = 1'b0; bus0.r_en = 1'b0; bus0.data_in = '0; bus0.err_clr = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        checks++;
        if (st0 !== exp_status(0)) begin
            errors++; $display("FAIL reset_status_reg: got %h expected %h", st0, exp_status(0));
        end
        checks++;
        if (st1 !== exp_status(0)) begin
            errors++; $display("FAIL reset_status_fwft: got %h expected %h", st1, exp_status(0));
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus0.data_out !== 8'h00) begin
            errors++; $display("FAIL reset_data_out: got %h expected 00", bus0.data_out);
        end
        checks++;
        if ({bus0.write_error, bus0.read_error, bus1.write_error, bus1.read_error} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_errors: got %b%b%b%b expected 0000", bus0.write_error,
                     bus0.read_error, bus1.write_error, bus1.read_error);
        end
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_fill_drain_thresholds();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            checks++;
            if (st0 !== exp_status(i + 1)) begin
                errors++; $display("FAIL fill_status_reg[%0d]: got %h expected %h", i, st0, exp_status(i + 1));
            end
            checks++;
            if (st1 !== exp_status(i + 1)) begin
                errors++; $display("FAIL fill_status_fwft[%0d]: got %h expected %h", i, st1, exp_status(i + 1));
            end
        end
        checks++;
        if (bus0.full !== 1'b1 || bus0.count !== 5'd16) begin
            errors++; $display("FAIL full_after_16: got full=%b count=%0d expected full=1 count=16", bus0.full, bus0.count);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus1.data_out !== 8'(i)) begin
                errors++; $display("FAIL drain_fwft_head[%0d]: got %h expected %h", i, bus1.data_out, 8'(i));
            end
            step(1'b0, 1'b1, 8'h00, 1'b0);
            checks++;
            if (bus0.data_out !== 8'(i)) begin
                errors++; $display("FAIL drain_data_reg[%0d]: got %h expected %h", i, bus0.data_out, 8'(i));
            end
            checks++;
            if (st0 !== exp_status(15 - i)) begin
                errors++; $display("FAIL drain_status_reg[%0d]: got %h expected %h", i, st0, exp_status(15 - i));
            end
        end
        checks++;
        if (bus0.empty !== 1'b1 || bus0.count !== 5'd0) begin
            errors++; $display("FAIL empty_after_drain: got empty=%b count=%0d expected empty=1 count=0", bus0.empty, bus0.count);
        end
    endtask

    task automatic test_overflow_underflow();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h20 + 8'(i), 1'b0);
        step(1'b1, 1'b0, 8'hEE, 1'b0);
        checks++;
        if (bus0.write_error !== 1'b1 || bus0.count !== 5'd16) begin
            errors++; $display("FAIL overflow: got werr=%b count=%0d expected werr=1 count=16", bus0.write_error, bus0.count);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (bus1.write_error !== 1'b1) begin
            errors++; $display("FAIL werr_sticky: got %b expected 1", bus1.write_error);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (bus0.write_error !== 1'b0) begin
            errors++; $display("FAIL werr_clear: got %b expected 0", bus0.write_error);
        end
        step(1'b1, 1'b0, 8'hEF, 1'b1);
        checks++;
        if (bus0.write_error !== 1'b1) begin
            errors++; $display("FAIL werr_set_wins: got %b expected 1", bus0.write_error);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            checks++;
            if (bus0.data_out !== 8'h20 + 8'(i)) begin
                errors++; $display("FAIL overflow_mem_intact[%0d]: got %h expected %h", i, bus0.data_out, 8'h20 + 8'(i));
            end
        end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (bus0.read_error !== 1'b1 || bus0.count !== 5'd0 || bus0.data_out !== 8'h2F) begin
            errors++;
            $display("FAIL underflow: got rerr=%b count=%0d dout=%h expected rerr=1 count=0 dout=2f",
                     bus0.read_error, bus0.count, bus0.data_out);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (bus1.read_error !== 1'b0 || bus1.write_error !== 1'b0) begin
            errors++; $display("FAIL rerr_clear: got rerr=%b werr=%b expected 0 0", bus1.read_error, bus1.write_error);
        end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] seq [15];
        for (int k = 0; k < 15; k++) seq[k] = (k < 5) ? 8'h30 + 8'(k) : 8'h40 + 8'(k - 5);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h30 + 8'(i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 8'h40 + 8'(i), 1'b0);
            checks++;
            if (bus0.count !== 5'd5 || bus1.count !== 5'd5) begin
                errors++; $display("FAIL simul_count[%0d]: got %0d/%0d expected 5", i, bus0.count, bus1.count);
            end
            checks++;
            if (bus0.data_out !== seq[i] || bus1.data_out !== seq[i + 1]) begin
                errors++;
                $display("FAIL simul_order[%0d]: got reg=%h fwft=%h expected reg=%h fwft=%h",
                         i, bus0.data_out, bus1.data_out, seq[i], seq[i + 1]);
            end
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (bus0.data_out !== 8'h49 || bus0.empty !== 1'b1) begin
            errors++; $display("FAIL simul_tail: got dout=%h empty=%b expected 49 1", bus0.data_out, bus0.empty);
        end
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h50 + 8'(i), 1'b0);
        step(1'b1, 1'b1, 8'hFF, 1'b0);
        checks++;
        if (bus0.count !== 5'd15 || bus0.write_error !== 1'b1 || bus0.read_error !== 1'b0) begin
            errors++;
            $display("FAIL full_both: got count=%0d werr=%b rerr=%b expected 15 1 0",
                     bus0.count, bus0.write_error, bus0.read_error);
        end
        checks++;
        if (bus0.data_out !== 8'h50 || bus1.data_out !== 8'h51) begin
            errors++; $display("FAIL full_both_data: got reg=%h fwft=%h expected 50 51", bus0.data_out, bus1.data_out);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (bus0.data_out !== 8'h5F || st0 !== exp_status(0)) begin
            errors++; $display("FAIL full_both_drain: got dout=%h st=%h expected 5f %h", bus0.data_out, st0, exp_status(0));
        end
    endtask

    task automatic test_fwft();
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        checks++;
        if (bus1.data_out !== 8'hA5) begin
            errors++; $display("FAIL fwft_fallthrough: got %h expected a5", bus1.data_out);
        end
        checks++;
        if (bus0.data_out !== 8'h5F || bus0.count !== 5'd1) begin
            errors++; $display("FAIL reg_hold: got dout=%h count=%0d expected 5f 1", bus0.data_out, bus0.count);
        end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (bus0.data_out !== 8'hA5 || bus1.empty !== 1'b1) begin
            errors++; $display("FAIL fwft_pop: got dout=%h empty=%b expected a5 1", bus0.data_out, bus1.empty);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h60 + 8'(i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, (i % 4) != 3, 8'h63 + 8'(i), 1'b0);
            if ((i % 4) != 3) begin
                checks++;
                if (bus0.data_out !== popped) begin
                    errors++; $display("FAIL wrap_reg[%0d]: got %h expected %h", i, bus0.data_out, popped);
                end
            end
            checks++;
            if (bus1.data_out !== exp_q[0]) begin
                errors++; $display("FAIL wrap_fwft[%0d]: got %h expected %h", i, bus1.data_out, exp_q[0]);
            end
        end
        while (exp_q.size() > 0) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            checks++;
            if (bus0.data_out !== popped) begin
                errors++; $display("FAIL wrap_drain: got %h expected %h", bus0.data_out, popped);
            end
        end
        checks++;
        if (popped !== 8'h8A || st1 !== exp_status(0)) begin
            errors++; $display("FAIL wrap_end: got last=%h st=%h expected 8a %h", popped, st1, exp_status(0));
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'h70 + 8'(i), 1'b0);
        checks++;
        if (st0 !== exp_status(9)) begin
            errors++; $display("FAIL pre_reset: got %h expected %h", st0, exp_status(9));
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (st0 !== exp_status(0) || st1 !== exp_status(0) || bus0.data_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got reg=%h fwft=%h dout=%h expected %h %h 00",
                     st0, st1, bus0.data_out, exp_status(0), exp_status(0));
        end
        #1 rst = 1'b0;
        exp_q.delete();
        step(1'b1, 1'b0, 8'h5A, 1'b0);
        checks++;
        if (bus0.count !== 5'd1 || bus1.data_out !== 8'h5A) begin
            errors++; $display("FAIL post_reset_write: got count=%0d fwft=%h expected 1 5a", bus0.count, bus1.data_out);
        end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (bus0.data_out !== 8'h5A || bus0.empty !== 1'b1) begin
            errors++; $display("FAIL post_reset_read: got dout=%h empty=%b expected 5a 1", bus0.data_out, bus0.empty);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        popped = '0;
        test_reset();
        test_fill_drain_thresholds();
        test_overflow_underflow();
        test_simultaneous();
        test_fwft();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_mode_fifo.md
MULTI_MODE_FIFO -- requirements
Module: multi_mode_fifo

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8: data word width in bits.
REQ-002 SHALL provide parameter DEPTH, default 256: entry count, power of two, legal range 4..4096.
REQ-003 SHALL provide parameter PTR_WIDTH, default 8: log2(DEPTH).
REQ-004 SHALL provide parameter FWFT, default 0: 0 = standard registered read, 1 = first-word-fall-through.
REQ-005 SHALL provide parameter AF_LEVEL, default DEPTH-4: almost_full threshold.
REQ-006 SHALL provide parameter AE_LEVEL, default 4: almost_empty threshold.
REQ-007 SHALL provide port clk, input, 1 bit: single clock, all logic rising-edge.
REQ-008 SHALL provide port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-009 SHALL provide ports w_en and r_en, each input, 1 bit: write and read requests.
REQ-010 SHALL provide port data_in, input, DATA_WIDTH bits: write data.
REQ-011 SHALL provide port err_clr, input, 1 bit: clears sticky error flags.
REQ-012 SHALL provide port data_out, output, DATA_WIDTH bits: read data.
REQ-013 SHALL provide port count, output, PTR_WIDTH+1 bits: current occupancy, 0..DEPTH.
REQ-014 SHALL provide status outputs full, empty, almost_full, almost_empty, half_full and half_empty, each 1 bit.
REQ-015 SHALL provide outputs write_error and read_error, each 1 bit, sticky.

Function
REQ-016 Write accept SHALL be w_en && !full; the accepted word is stored at wptr and wptr advances by 1, wrapping DEPTH-1 -> 0.
REQ-017 Read accept SHALL be r_en && !empty; rptr advances by 1 with the same wrap.
REQ-018 full and empty SHALL be evaluated on the current state: write when full is rejected even with a simultaneous accepted read, and read when empty is rejected even with a simultaneous write.
REQ-019 Simultaneous accepted read and write SHALL leave count unchanged.
REQ-020 count SHALL update as count_next = count + wr_acc - rd_acc, registered, and SHALL never exceed DEPTH or underflow.
REQ-021 All status flags SHALL be registered from count_next, so they are cycle-consistent with count:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count >= AF_LEVEL)
  - almost_empty = (count <= AE_LEVEL)
  - half_full = (count >= DEPTH/2)
  - half_empty = (count < DEPTH/2)
REQ-022 With FWFT=0, data_out SHALL be registered and SHALL show the popped word one cycle after the accepting edge; otherwise data_out holds its value.
REQ-023 With FWFT=1, data_out SHALL present mem[rptr] combinationally whenever !empty, SHALL advance to the next word on the edge after an accepted read, and is don't-care when empty.
REQ-024 A rejected write SHALL set write_error and a rejected read SHALL set read_error on the next edge; both hold until err_clr.
REQ-025 err_clr SHALL clear both error flags on the next edge; if a new error occurs in the same cycle, the set SHALL win.
REQ-026 Rejected operations SHALL NOT modify pointers, count or memory contents.
REQ-027 Write-then-read data ordering SHALL be strict FIFO across pointer wrap-around.

Reset
REQ-028 While rst=1, the block SHALL asynchronously force:
  - wptr=0, rptr=0, count=0
  - empty=1, half_empty=1, almost_empty=1
  - full=0, almost_full=0, half_full=0
  - write_error=0, read_error=0
  - data_out=0 (FWFT=0)
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 Reset asserted mid-operation SHALL discard all stored words.
REQ-031 The first accepted write SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-032 Fill/drain scenario: DEPTH=16, write 0x00..0x0F, then read 16 -> full=1 after 16th write with count=16; reads return 0x00..0x0F in order; empty=1 and count=0 at end.
REQ-033 Overflow/underflow scenario: write while full, then pulse err_clr; read while empty -> memory and count unchanged, write_error=1 until err_clr, read_error=1 after empty read.
REQ-034 Simultaneous access scenario: count=5, assert w_en and r_en together for 10 cycles -> count stays 5, data order preserved; with count=16 (full) both asserted -> read accepted, write rejected, count=15, write_error=1.
REQ-035 Threshold scenario: DEPTH=16, AF_LEVEL=12, AE_LEVEL=4, sweep count 0..16 -> almost_empty=1 for count<=4, almost_full=1 for count>=12, half_full=1 for count>=8, flags change on the same edge as count.
REQ-036 Mode and wrap scenario: FWFT=1, write 0xA5 into empty FIFO -> data_out=0xA5 the cycle after the write, before any r_en; in both modes, 40 writes/reads interleaved through pointer wrap return identical ordered data.
REQ-037 Reset mid-operation scenario: count=9, assert rst between clock edges -> count=0, empty=1 immediately; a write on the first edge after release is read back correctly.
